// File: rtl/pagerank_iter.sv
// PageRank power iteration over N nodes: one CONTRIB cycle, N ROW cycles and one COMMIT cycle per iteration.
// Ranks, weights and damping are unsigned WIDTH-bit fractions; start is ignored while busy.
module pagerank_iter #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int ITW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N*N-1:0]     adj,
  input  logic [N*WIDTH-1:0] nodeWeight,
  input  logic [WIDTH-1:0]   damping,
  input  logic [WIDTH-1:0]   tol,
  input  logic [ITW-1:0]     max_iter,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [ITW-1:0]     iter_count,
  output logic [N*WIDTH-1:0] node_val
);
  localparam int LG = $clog2(N);
  localparam int SW = WIDTH + LG;
  localparam int PW = SW + WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_CONTRIB, S_ROW, S_COMMIT, S_DONE} state_t;

  state_t           r_state;
  logic [N-1:0]     r_adj     [N];
  logic [WIDTH-1:0] r_w       [N];
  logic [WIDTH-1:0] r_rank    [N];
  logic [WIDTH-1:0] r_contrib [N];
  logic [WIDTH-1:0] r_next    [N];
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_tol;
  logic [ITW-1:0]   r_max;
  logic [ITW-1:0]   r_iter;
  logic [LG-1:0]    r_row;
  logic             r_done;
  logic             r_conv;

  logic [WIDTH-1:0] w_contrib [N];
  logic [SW-1:0]    w_sum;
  logic [PW-1:0]    w_prod;
  logic [SW-1:0]    w_dsum;
  logic [WIDTH:0]   w_one_m_d;
  logic [WIDTH:0]   w_base;
  logic [SW:0]      w_nsum;
  logic [WIDTH-1:0] w_nval;
  logic [WIDTH-1:0] w_diff;
  logic             w_conv;
  logic             w_last;

  always_comb begin
    for (int j = 0; j < N; j++)
      w_contrib[j] = WIDTH'(((2*WIDTH)'(r_rank[j]) * (2*WIDTH)'(r_w[j])) >> WIDTH);
  end

  // One row of the adjacency-weighted sum per ROW cycle, selected by r_row.
  always_comb begin
    w_sum = '0;
    for (int j = 0; j < N; j++)
      if (r_adj[r_row][j]) w_sum = w_sum + SW'(r_contrib[j]);
  end

  assign w_prod    = PW'(r_d) * PW'(w_sum);
  assign w_dsum    = SW'(w_prod >> WIDTH);
  assign w_one_m_d = {1'b1, {WIDTH{1'b0}}} - {1'b0, r_d};
  assign w_base    = w_one_m_d >> LG;
  assign w_nsum    = (SW+1)'(w_base) + (SW+1)'(w_dsum);
  assign w_nval    = (|w_nsum[SW:WIDTH]) ? '1 : w_nsum[WIDTH-1:0];

  always_comb begin
    w_conv = 1'b1;
    w_diff = '0;
    for (int i = 0; i < N; i++) begin
      w_diff = (r_next[i] >= r_rank[i]) ? (r_next[i] - r_rank[i]) : (r_rank[i] - r_next[i]);
      if (w_diff > r_tol) w_conv = 1'b0;
    end
  end

  assign w_last = (({1'b0, r_iter} + (ITW+1)'(1)) >= {1'b0, r_max});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_conv  <= 1'b0;
      r_iter  <= '0;
      r_row   <= '0;
      r_d     <= '0;
      r_tol   <= '0;
      r_max   <= '0;
      for (int i = 0; i < N; i++) begin
        r_adj[i]     <= '0;
        r_w[i]       <= '0;
        r_rank[i]    <= '0;
        r_contrib[i] <= '0;
        r_next[i]    <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) begin
              r_adj[i]  <= adj[i*N +: N];
              r_w[i]    <= nodeWeight[i*WIDTH +: WIDTH];
              r_rank[i] <= WIDTH'(1) << (WIDTH - LG);
            end
            r_d     <= damping;
            r_tol   <= tol;
            r_max   <= (max_iter == '0) ? ITW'(1) : max_iter;
            r_iter  <= '0;
            r_conv  <= 1'b0;
            r_state <= S_CONTRIB;
          end
        end
        S_CONTRIB: begin
          for (int j = 0; j < N; j++) r_contrib[j] <= w_contrib[j];
          r_row   <= '0;
          r_state <= S_ROW;
        end
        S_ROW: begin
          r_next[r_row] <= w_nval;
          if (r_row == LG'(N - 1)) r_state <= S_COMMIT;
          else                     r_row   <= r_row + LG'(1);
        end
        S_COMMIT: begin
          for (int i = 0; i < N; i++) r_rank[i] <= r_next[i];
          r_iter <= r_iter + ITW'(1);
          if (w_conv) begin
            r_conv  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_CONTRIB;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign converged  = r_conv;
  assign iter_count = r_iter;

  for (genvar i = 0; i < N; i++) begin : g_out
    assign node_val[i*WIDTH +: WIDTH] = r_rank[i];
  end
endmodule

// File: tb/tb_pagerank_iter.sv
// Directed-vector bench for pagerank_iter (N=4, WIDTH=16, ITW=8).
module tb_pagerank_iter;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] adj;
  logic [63:0] nodeWeight;
  logic [15:0] damping, tol;
  logic [7:0]  max_iter;
  logic        busy, done, converged;
  logic [7:0]  iter_count;
  logic [63:0] node_val;

  int n_chk = 0;
  int n_err = 0;
  int dcyc, dcnt;
  logic [63:0] snap;

  localparam logic [15:0] ADJ31 = 16'h3B1C;
  localparam logic [63:0] W31   = 64'h8000_FFFF_8000_5555;
  localparam logic [63:0] EXP31 = 64'h3554_5554_1554_5FFE;

  pagerank_iter #(.N(4), .WIDTH(16), .ITW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .adj(adj), .nodeWeight(nodeWeight),
    .damping(damping), .tol(tol), .max_iter(max_iter), .busy(busy), .done(done),
    .converged(converged), .iter_count(iter_count), .node_val(node_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // mode 0: plain run; mode 1: reset asserted in ROW (returns with reset high);
  // mode 2: start re-pulsed and inputs scrambled mid-run.
  // Cycle c is sampled at the negedge following the (c-1)th posedge after the start-sampling edge.
  task automatic run(input logic [15:0] a, input logic [63:0] w, input logic [15:0] d,
                     input logic [15:0] t, input logic [7:0] m, input int mode,
                     output int o_dcyc, output int o_dcnt, output logic [63:0] o_snap);
    @(negedge clk);
    adj = a; nodeWeight = w; damping = d; tol = t; max_iter = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    o_dcyc = -1; o_dcnt = 0; o_snap = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) check("busy_after_start", 64'(busy), 64'd1);
      if (c == 7) o_snap = node_val;
      if (done) begin
        o_dcnt++;
        if (o_dcyc < 0) o_dcyc = c;
      end
      if (mode == 1 && c == 3) begin
        reset = 1'b1;
        @(negedge clk);
        return;
      end
      if (mode == 2 && c == 2) begin
        start = 1'b1; adj = '1; nodeWeight = '0; damping = '0; tol = 16'hFFFF; max_iter = 8'd9;
      end
      if (mode == 2 && c == 3) start = 1'b0;
      if (mode != 2 && o_dcyc >= 0 && c >= o_dcyc + 2) break;
      if (mode == 2 && c >= 30) break;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; adj = '0; nodeWeight = '0; damping = '0; tol = '0; max_iter = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_conv", 64'(converged), 64'd0);
    check("rst_iter", 64'(iter_count), 64'd0);
    check("rst_nodes", node_val, 64'd0);
    reset = 1'b0;

    // Zero damping: every rank lands on the uniform base after one iteration.
    run(16'hA5C3, 64'h1234_5678_9ABC_DEF0, 16'h0000, 16'h0000, 8'd5, 0, dcyc, dcnt, snap);
    check("d0_done_cyc", 64'(dcyc), 64'd7);
    check("d0_done_cnt", 64'(dcnt), 64'd1);
    check("d0_nodes", node_val, 64'h4000_4000_4000_4000);
    check("d0_conv", 64'(converged), 64'd1);
    check("d0_iter", 64'(iter_count), 64'd1);
    check("d0_busy_end", 64'(busy), 64'd0);

    run(ADJ31, W31, 16'hFFFF, 16'h0000, 8'd1, 0, dcyc, dcnt, snap);
    check("g1_done_cyc", 64'(dcyc), 64'd7);
    check("g1_nodes", node_val, EXP31);
    check("g1_conv", 64'(converged), 64'd0);
    check("g1_iter", 64'(iter_count), 64'd1);

    // Fully connected, max weights: second iteration saturates.
    run(16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 16'h0000, 8'd2, 0, dcyc, dcnt, snap);
    check("sat_iter1_nodes", snap, 64'hFFFB_FFFB_FFFB_FFFB);
    check("sat_done_cyc", 64'(dcyc), 64'd13);
    check("sat_nodes", node_val, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sat_iter", 64'(iter_count), 64'd2);
    check("sat_conv", 64'(converged), 64'd0);

    run(ADJ31, W31, 16'hFFFF, 16'h0000, 8'd0, 0, dcyc, dcnt, snap);
    check("mi0_done_cyc", 64'(dcyc), 64'd7);
    check("mi0_nodes", node_val, EXP31);
    check("mi0_iter", 64'(iter_count), 64'd1);
    repeat (4) @(negedge clk);
    check("mi0_hold_nodes", node_val, EXP31);
    check("mi0_hold_iter", 64'(iter_count), 64'd1);

    // Reset in ROW, then reset together with start.
    run(ADJ31, W31, 16'hFFFF, 16'h0000, 8'd1, 1, dcyc, dcnt, snap);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_conv", 64'(converged), 64'd0);
    check("midrst_iter", 64'(iter_count), 64'd0);
    check("midrst_nodes", node_val, 64'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check("rststart_busy", 64'(busy), 64'd0);
    check("rststart_nodes", node_val, 64'd0);
    @(negedge clk);
    check("rststart_idle", 64'(busy), 64'd0);
    run(ADJ31, W31, 16'hFFFF, 16'h0000, 8'd1, 0, dcyc, dcnt, snap);
    check("restart_done_cyc", 64'(dcyc), 64'd7);
    check("restart_nodes", node_val, EXP31);

    // Disturbed run must match the undisturbed one.
    run(ADJ31, W31, 16'hFFFF, 16'h0000, 8'd1, 2, dcyc, dcnt, snap);
    check("dist_done_cyc", 64'(dcyc), 64'd7);
    check("dist_done_cnt", 64'(dcnt), 64'd1);
    check("dist_nodes", node_val, EXP31);
    check("dist_conv", 64'(converged), 64'd0);
    check("dist_iter", 64'(iter_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
